// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default oversample
// ratio and the odd-parity helper also used by uart_tx.
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

    // Returns the bit that makes the total number of ones odd. Narrower
    // words are zero-extended by the caller, which does not change the result.
    function automatic logic odd_parity_bit(input logic [31:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side receive bundle: parallel word, frame strobe, error flags, busy.
// master = uart_rx (driver), slave = consumer.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_error;
    logic                 frame_error;
    logic                 rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_error,
        output frame_error,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input parity_error,
        input frame_error,
        input rx_busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
// RESET_VAL sets the value both flops take during reset (idle level).
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: plain two-stage pipeline.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, forced to the idle level in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS data LSB-first, optional odd parity,
// 1 stop. Samples the synchronized line on an oversampled tick.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: bit decisions use a 2-of-3
// vote over the last three tick samples instead of a single sample.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RX_IDLE   | line idle, waiting for a low sample on a tick
// RX_START  | confirming the start bit at its centre
// RX_DATA   | sampling data bits at each bit centre
// RX_PARITY | sampling the parity bit
// RX_STOP   | sampling the stop bit, publishing the frame
// RX_BREAK  | stop bit was low; waiting for the line to go high again
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      sample_tick,
    input  logic      rx_pin,
    input  logic      parity_enable,
    uart_rx_if.master rx_if
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic rx_s;
    logic bit_val;

    rx_state_e            state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_reg_q, shift_reg_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_error_q, parity_error_d;
    logic                 frame_error_q, frame_error_d;
    logic                 rx_busy_q, rx_busy_d;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .d     (rx_pin),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [2:0] vote_q, vote_d;

    // Shift in one line sample per tick; the vote sees the last three.
    always_comb begin
        vote_d = vote_q;
        if (sample_tick) begin
            vote_d = {vote_q[1:0], rx_s};
        end
    end

    // Vote history starts at the idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vote_q <= 3'b111;
        end else begin
            vote_q <= vote_d;
        end
    end

    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) |
                     (vote_q[1] & vote_q[2]);
`else
    assign bit_val = rx_s;
`endif

    // Frame FSM next-state and output computation; all work happens on ticks.
    always_comb begin
        state_d        = state_q;
        tick_cnt_d     = tick_cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_reg_d    = shift_reg_q;
        par_en_d       = par_en_q;
        par_bit_d      = par_bit_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        parity_error_d = parity_error_q;
        frame_error_d  = frame_error_q;

        if (sample_tick) begin
            case (state_q)
                RX_IDLE: begin
                    // Start detection always uses the single synchronized sample.
                    if (!rx_s) begin
                        state_d    = RX_START;
                        tick_cnt_d = '0;
                        par_en_d   = parity_enable;
                    end
                end
                RX_START: begin
                    if (tick_cnt_q == TICK_HALF) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = bit_val ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d  = '0;
                        shift_reg_d = {bit_val, shift_reg_q[DATA_BITS-1:1]};
                        if (bit_idx_q == IDX_LAST) begin
                            state_d = par_en_q ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        par_bit_d  = bit_val;
                        state_d    = RX_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d     = '0;
                        rx_data_d      = shift_reg_q;
                        parity_error_d = par_en_q &
                                         (par_bit_q != odd_parity_bit(32'(shift_reg_q)));
                        frame_error_d  = ~bit_val;
                        rx_valid_d     = 1'b1;
                        // A low stop bit parks in BREAK so a held-low line
                        // cannot retrigger a new frame.
                        state_d        = bit_val ? RX_IDLE : RX_BREAK;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end
                end
                default: begin
                    state_d = RX_IDLE;
                end
            endcase
        end

        rx_busy_d = (state_d != RX_IDLE);
    end

    // State and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RX_IDLE;
            tick_cnt_q     <= '0;
            bit_idx_q      <= '0;
            shift_reg_q    <= '0;
            par_en_q       <= 1'b0;
            par_bit_q      <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_reg_q    <= shift_reg_d;
            par_en_q       <= par_en_d;
            par_bit_q      <= par_bit_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            parity_error_q <= parity_error_d;
            frame_error_q  <= frame_error_d;
            rx_busy_q      <= rx_busy_d;
        end
    end

    assign rx_if.rx_data      = rx_data_q;
    assign rx_if.rx_valid     = rx_valid_q;
    assign rx_if.parity_error = parity_error_q;
    assign rx_if.frame_error  = frame_error_q;
    assign rx_if.rx_busy      = rx_busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level reference model.
module tb_uart_rx;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    localparam int TICK_DIV   = 4;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } frame_t;

    logic clk           = 1'b0;
    logic reset         = 1'b1;
    logic sample_tick   = 1'b0;
    logic rx_pin        = 1'b1;
    logic parity_enable = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int div_cnt = 0;

    frame_t got_q[$];

    uart_rx_if #(.DATA_BITS(DATA_BITS)) rx_if ();

    uart_rx #(
        .DATA_BITS  (DATA_BITS),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .rx_pin        (rx_pin),
        .parity_enable (parity_enable),
        .rx_if         (rx_if)
    );

    always #5 clk = ~clk;

    // Baud-generator stand-in: one tick every TICK_DIV clocks.
    always @(negedge clk) begin
        sample_tick = (div_cnt == 0);
        div_cnt     = (div_cnt + 1) % TICK_DIV;
    end

    // Collect every published frame.
    always @(negedge clk) begin
        if (rx_if.rx_valid === 1'b1) begin
            got_q.push_back('{rx_if.rx_data, rx_if.parity_error, rx_if.frame_error});
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (sample_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_pin = v;
        wait_ticks(OVERSAMPLE);
    endtask

    // Reference: frame-level meaning of the serial bits.
    function automatic frame_t model(input logic [7:0] data, input logic pen,
                                     input logic pbit, input logic stop);
        frame_t f;
        f.data = data;
        f.pe   = pen && ((($countones(data) + int'(pbit)) % 2) == 0);
        f.fe   = !stop;
        return f;
    endfunction

    // Serial frame; parity_enable is scrambled after the start bit to show
    // that only its value at the start matters.
    task automatic send_frame(input logic [7:0] data, input logic pen,
                              input logic pbit, input logic stop);
        parity_enable = pen;
        drive_bit(1'b0);
        parity_enable = 1'($urandom_range(0, 1));
        for (int i = 0; i < DATA_BITS; i++) drive_bit(data[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic check_frame(input string tag, input frame_t exp);
        frame_t f;
        check({tag, "_cnt"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) begin
            f = got_q.pop_front();
            check({tag, "_data"}, 32'(f.data), 32'(exp.data));
            check({tag, "_perr"}, 32'(f.pe), 32'(exp.pe));
            check({tag, "_ferr"}, 32'(f.fe), 32'(exp.fe));
        end
        got_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(rx_if.rx_data), 32'd0);
        check({tag, "_valid"}, 32'(rx_if.rx_valid), 32'd0);
        check({tag, "_perr"},  32'(rx_if.parity_error), 32'd0);
        check({tag, "_ferr"},  32'(rx_if.frame_error), 32'd0);
        check({tag, "_busy"},  32'(rx_if.rx_busy), 32'd0);
    endtask

    // Clean frame: check contents and that the receiver is idle after stop.
    task automatic run_frame(input string tag, input logic [7:0] data, input logic pen,
                             input logic pbit);
        send_frame(data, pen, pbit, 1'b1);
        check_frame(tag, model(data, pen, pbit, 1'b1));
        check({tag, "_idle"}, 32'(rx_if.rx_busy), 32'd0);
    endtask

    // Low stop bit followed by a held-low line, then release.
    task automatic run_break(input string tag, input logic [7:0] data, input logic pen,
                             input logic pbit, input int hold_bits);
        send_frame(data, pen, pbit, 1'b0);
        check_frame(tag, model(data, pen, pbit, 1'b0));
        wait_ticks(hold_bits * OVERSAMPLE);
        check({tag, "_hold_busy"}, 32'(rx_if.rx_busy), 32'd1);
        check({tag, "_hold_cnt"}, 32'(got_q.size()), 32'd0);
        rx_pin = 1'b1;
        wait_ticks(4);
        check({tag, "_rel_busy"}, 32'(rx_if.rx_busy), 32'd0);
        wait_ticks(OVERSAMPLE);
    endtask

    initial begin
        logic [7:0] d;
        logic       pen, pbit, stop;
        int         gap;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        wait_ticks(8);
        check("post_reset_busy", 32'(rx_if.rx_busy), 32'd0);

        // 1: plain frame
        run_frame("t1_a5", 8'hA5, 1'b0, 1'b0);

        // 2: odd parity good and bad
        run_frame("t2_par_ok", 8'h03, 1'b1, 1'b1);
        run_frame("t2_par_bad", 8'h03, 1'b1, 1'b0);

        // 3: false start
        rx_pin = 1'b0;
        wait_ticks(3);
        check("t3_busy_low", 32'(rx_if.rx_busy), 32'd1);
        wait_ticks(1);
        rx_pin = 1'b1;
        wait_ticks(12);
        check("t3_idle", 32'(rx_if.rx_busy), 32'd0);
        check("t3_no_valid", 32'(got_q.size()), 32'd0);
        // flags untouched by the false start
        check("t3_perr_held", 32'(rx_if.parity_error), 32'd1);
        check("t3_data_held", 32'(rx_if.rx_data), 32'h03);

        // 4: break (30 bit times low in total), then clean frame
        run_break("t4_brk", 8'h00, 1'b0, 1'b0, 30 - 10);
        run_frame("t4_3c", 8'h3C, 1'b0, 1'b0);

        // 5: reset during data bit 4
        d = 8'hC3;
        parity_enable = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_pin = d[4];
        wait_ticks(8);
        reset = 1'b1;
        #2;
        check_reset_outputs("t5_rst");
        rx_pin = 1'b1;
        wait_ticks(4);
        reset = 1'b0;
        wait_ticks(2 * OVERSAMPLE);
        check("t5_no_valid", 32'(got_q.size()), 32'd0);
        check("t5_idle", 32'(rx_if.rx_busy), 32'd0);
        run_frame("t5_5a", 8'h5A, 1'b0, 1'b0);

        // 6: back-to-back, no idle gap
        run_frame("t6_00", 8'h00, 1'b0, 1'b0);
        run_frame("t6_ff", 8'hFF, 1'b0, 1'b0);

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom_range(0, 255));
            pen  = 1'($urandom_range(0, 1));
            pbit = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 7) != 0);
            gap  = int'($urandom_range(0, 20));
            if (stop) begin
                run_frame($sformatf("rnd%0d", n), d, pen, pbit);
            end else begin
                run_break($sformatf("rnd%0d_brk", n), d, pen, pbit, 2);
            end
            wait_ticks(gap);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; the receive-side counterpart of the team's uart_tx. It samples an asynchronous serial line using an oversampled tick from the shared baud generator. Frame format: 1 start bit (0), DATA_BITS data bits LSB-first, optional odd parity bit, 1 stop bit (1). Delivers each frame as a parallel word with a one-clk valid pulse and per-frame error flags to the host-side logic.

Parameters:
DATA_BITS, 8, data bits per frame (>=5)
OVERSAMPLE, 16, sample_tick pulses per bit period (even, >=4)

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
rx_pin  input  1  asynchronous serial line, idle high
parity_enable  input  1  1 = expect odd parity bit after data
rx_data  output  DATA_BITS  last received word; held until next frame completes
rx_valid  output  1  one-clk pulse, frame complete
parity_error  output  1  parity mismatch for the frame in rx_data
frame_error  output  1  stop bit sampled 0 for the frame in rx_data
rx_busy  output  1  high whenever state != IDLE

Behaviour:
- rx_pin passes through a 2-FF synchronizer (rx_s); flops reset to 1. All line decisions use rx_s.
- Reset values: rx_data=0, rx_valid=0, parity_error=0, frame_error=0, rx_busy=0, state=IDLE, counters=0.
- Reset mid-frame aborts immediately: no rx_valid; the partial word is discarded.
- tick_cnt: width $clog2(OVERSAMPLE); advances only on clk edges where sample_tick=1.
- IDLE: on a sample_tick with rx_s=0 -> START, tick_cnt=0; latch parity_enable into par_en_q (held for the whole frame).
- START: at tick_cnt == OVERSAMPLE/2-1 (bit centre), if rx_s=0 -> DATA with tick_cnt=0, bit_idx=0; if rx_s=1 -> IDLE (false start, no outputs change).
- DATA: at tick_cnt == OVERSAMPLE-1, sample rx_s, shift it into the MSB of shift_reg (right shift, so LSB-first), tick_cnt=0. After DATA_BITS samples -> PARITY if par_en_q, else STOP.
- PARITY: at tick_cnt == OVERSAMPLE-1, capture par_bit -> STOP.
- STOP: at tick_cnt == OVERSAMPLE-1, sample the stop bit, then in the same edge:
  - rx_data <= shift_reg
  - parity_error <= par_en_q & ~(^{shift_reg, par_bit}); odd parity means the total count of ones must be odd
  - frame_error <= ~rx_s
  - rx_valid <= 1 for exactly one clk
  - next state: IDLE if rx_s=1; BREAK if rx_s=0.
- BREAK: wait until rx_s=1 on a sample_tick, then -> IDLE. A held-low line produces exactly one frame (frame_error=1), never a retrigger.
- Error flags are not sticky. They update only together with rx_valid and are otherwise held.
- There is no backpressure. rx_data is overwritten at the next frame's completion, and the consumer must read on rx_valid.
- parity_enable changes mid-frame have no effect until the next start.
- A new start bit is accepted on the first sample_tick after returning to IDLE, so back-to-back frames with a single stop bit are supported.

Optional Feature:
UART_RX_MAJORITY_VOTE_EN
- Defined: a 3-entry shift register captures rx_s on every sample_tick. Every bit decision (start confirm, data, parity, stop) uses the 2-of-3 majority of the last three samples instead of the single rx_s value. Start detection in IDLE still uses single rx_s.
- Undefined: single-sample decisions exactly as described in Behaviour.
- Timing and outputs are otherwise identical.

Decomposition:
- uart_pkg: rx state enum (IDLE, START, DATA, PARITY, STOP, BREAK), default OVERSAMPLE, odd-parity helper function shared with uart_tx.
- One sub-module: uart_sync2, a generic 2-FF synchronizer with a reset-value parameter, reused for other async inputs.

Test Plan:
1. DATA_BITS=8, OVERSAMPLE=16, parity off, frame 0xA5 -> single rx_valid pulse; rx_data=0xA5; parity_error=0; frame_error=0; rx_busy falls after stop.
2. parity on, 0x03 with parity bit 1 -> parity_error=0. Same data with parity bit 0 -> rx_data=0x03, parity_error=1.
3. rx_pin low for 4 ticks then high -> returns to IDLE, no rx_valid, rx_busy high only during that window.
4. 0x00 with stop bit 0, line held low 30 bit times -> exactly one rx_valid with rx_data=0x00, frame_error=1. After line high, frame 0x3C is received cleanly.
5. Reset asserted during DATA bit 4 -> all outputs return to reset values, no rx_valid; next frame 0x5A is received correctly.
6. Back-to-back 0x00 then 0xFF, single stop bits, no idle gap -> two rx_valid pulses with rx_data 0x00 then 0xFF, no errors.
